if_prefetch_unit: RTL

//  Parametrised instruction-fetch front end for the ECNURVCORE family: replaces the single-cycle IF stage.

---
 rtl/if_prefetch_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch prefetch front end: PC, in-order imem request channel, DEPTH-entry output FIFO.
// Optional macro IF_PREFETCH_BYPASS_EN: a live response reaching an empty FIFO is forwarded to out_* in the same cycle.
module if_prefetch_unit #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
    output logic            halted,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUTST) + 1;
    localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HALT} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] fifo_pc    [DEPTH];
    logic [XLEN-1:0] fifo_instr [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [OW-1:0]   outst, drop;
    logic [XLEN-1:0] pc_queue [MAX_OUTST];
    logic [QW-1:0]   pq_wr, pq_rd;

    logic accept, rsp_live, bypass, push, pop, fifo_valid;

    function automatic logic [QW-1:0] pq_inc(input logic [QW-1:0] p);
        if (32'(p) == MAX_OUTST - 1) return '0;
        else                         return p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_BOOT:  state_nxt = S_FETCH;
            S_FETCH: if (halt_req)  state_nxt = S_HALT;
            S_HALT:  if (!halt_req) state_nxt = S_FETCH;
            default: state_nxt = S_BOOT;
        endcase
    end

    // Credit check: every accepted request is guaranteed a FIFO slot, so responses never stall.
    assign imem_req_valid = (state == S_FETCH) && !redirect_valid
                            && (32'(outst) < MAX_OUTST)
                            && (32'(count) + 32'(outst) < DEPTH);
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign halted         = halt_req && (state == S_HALT) && (outst == '0);

    assign rsp_live   = imem_rsp_valid && (drop == '0) && !redirect_valid;
    assign fifo_valid = (count != '0) && !redirect_valid;
`ifdef IF_PREFETCH_BYPASS_EN
    assign bypass     = rsp_live && (count == '0) && out_ready;
`else
    assign bypass     = 1'b0;
`endif
    assign push       = rsp_live && !bypass;
    assign pop        = fifo_valid && out_ready;
    assign out_valid  = fifo_valid || bypass;

    always_comb begin
        out_pc    = '0;
        out_instr = '0;
        if (bypass) begin
            out_pc    = pc_queue[pq_rd];
            out_instr = imem_rsp_data;
        end else if (count != '0) begin
            out_pc    = fifo_pc[rd_ptr];
            out_instr = fifo_instr[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= pc_queue[pq_rd];
            fifo_instr[wr_ptr] <= imem_rsp_data;
        end
        if (accept) pc_queue[pq_wr] <= pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            outst  <= '0;
            drop   <= '0;
            pq_wr  <= '0;
            pq_rd  <= '0;
        end else begin
            if (accept) begin
                pc    <= pc + XLEN'(4);
                pq_wr <= pq_inc(pq_wr);
            end
            // Stale responses still retire their PC-queue entry; they are always the oldest ones.
            if (imem_rsp_valid) pq_rd <= pq_inc(pq_rd);

            unique case ({accept, imem_rsp_valid})
                2'b10:   outst <= outst + 1'b1;
                2'b01:   outst <= outst - 1'b1;
                default: outst <= outst;
            endcase

            if (redirect_valid) begin
                pc     <= {redirect_pc[XLEN-1:2], 2'b00};
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                // Every request still in flight after this cycle belongs to the old stream.
                drop   <= outst - {{(OW-1){1'b0}}, imem_rsp_valid};
            end else begin
                if (imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule
